// File: rtl/eth_tx_pkg.sv
// Shared types and the round-robin selection helper for the TX packet arbiter.
package eth_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

    localparam int unsigned MAX_SRCS = 8;

    // Returns {found, index} of the first request at or after ptr, wrapping modulo n.
    function automatic logic [3:0] rr_select(input logic [MAX_SRCS-1:0] req,
                                             input int unsigned         ptr,
                                             input int unsigned         n);
        logic [2:0] idx;
        logic [2:0] sel;
        logic       found;
        sel   = 3'd0;
        found = 1'b0;
        for (int unsigned off = 0; off < MAX_SRCS; off++) begin
            if (off < n) begin
                idx = 3'((ptr + off) % n);
                if (!found && req[idx]) begin
                    sel   = idx;
                    found = 1'b1;
                end
            end
        end
        return {found, sel};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr_i.
module rr_arbiter
    import eth_tx_pkg::*;
#(
    parameter int unsigned NUM_SRCS = 4
) (
    input  logic [0:NUM_SRCS-1]         req_i,
    input  logic [$clog2(NUM_SRCS)-1:0] ptr_i,
    output logic [0:NUM_SRCS-1]         gnt_o
);

    logic [MAX_SRCS-1:0] req_w;
    logic [3:0]          pick;

    always_comb begin
        req_w = '0;
        for (int i = 0; i < NUM_SRCS; i++) begin
            req_w[i] = req_i[i];
        end
        pick  = rr_select(req_w, 32'(ptr_i), NUM_SRCS);
        gnt_o = '0;
        for (int i = 0; i < NUM_SRCS; i++) begin
            gnt_o[i] = pick[3] && (pick[2:0] == 3'(i));
        end
    end

endmodule

// File: rtl/eth_tx_pkt_arbiter.sv
// Whole-packet round-robin arbiter merging per-source byte streams into one TX MAC stream,
// with oversize truncation/flush and a programmable inter-packet gap.
module eth_tx_pkt_arbiter
    import eth_tx_pkg::*;
#(
    parameter int unsigned NUM_SRCS      = 4,
    parameter int unsigned MAX_PKT_BYTES = 1518,
    parameter int unsigned IPG_CYCLES    = 12
) (
    input  logic                      i_txmac_clk,
    input  logic                      i_txmac_srst,
    input  logic [0:NUM_SRCS-1][7:0]  i_src_byte,
    input  logic [0:NUM_SRCS-1]       i_src_byte_vld,
    input  logic [0:NUM_SRCS-1]       i_src_last_byte,
    output logic [0:NUM_SRCS-1]       o_src_byte_rd,
    output logic [7:0]                o_byte,
    output logic                      o_byte_vld,
    output logic                      o_last_byte,
    input  logic                      i_byte_rd,
    output logic [0:NUM_SRCS-1]       o_grant,
    output logic                      o_busy,
    output logic                      o_oversize_error
);

    localparam int unsigned        PTR_W     = $clog2(NUM_SRCS);
    localparam int unsigned        CNT_W     = $clog2(MAX_PKT_BYTES + 1);
    localparam logic [CNT_W-1:0]   CNT_TRUNC = CNT_W'(MAX_PKT_BYTES - 1);
    localparam logic [7:0]         GAP_LAST  = 8'((IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0);
    localparam logic [PTR_W-1:0]   PTR_MAX   = PTR_W'(NUM_SRCS - 1);

    arb_state_e          state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    gidx_q, gidx_d;
    logic [0:NUM_SRCS-1] grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          gap_q, gap_d;
    logic                ovf_q, ovf_d;

    logic [0:NUM_SRCS-1] arb_gnt;
    logic [PTR_W-1:0]    arb_idx;
    logic [PTR_W-1:0]    ptr_next;
    logic [0:NUM_SRCS-1] rd_w;
    logic                vld_w, last_w;
    logic [7:0]          g_byte;
    logic                g_vld, g_last;

    rr_arbiter #(
        .NUM_SRCS (NUM_SRCS)
    ) u_rr (
        .req_i (i_src_byte_vld),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_SRCS; i++) begin
            if (arb_gnt[i]) arb_idx = PTR_W'(i);
        end
    end

    assign ptr_next = (gidx_q == PTR_MAX) ? '0 : gidx_q + PTR_W'(1);
    assign g_byte   = i_src_byte[gidx_q];
    assign g_vld    = i_src_byte_vld[gidx_q];
    assign g_last   = i_src_last_byte[gidx_q];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        ovf_d    = 1'b0;
        rd_w     = '0;
        vld_w    = 1'b0;
        last_w   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|i_src_byte_vld) begin
                    grant_d = arb_gnt;
                    gidx_d  = arb_idx;
                    cnt_d   = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                vld_w        = g_vld;
                last_w       = g_last || (cnt_q == CNT_TRUNC);
                rd_w[gidx_q] = i_byte_rd && g_vld;
                if (g_vld && i_byte_rd) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (g_last) begin
                        rr_ptr_d = ptr_next;
                        grant_d  = '0;
                        gap_d    = '0;
                        state_d  = (IPG_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end else if (cnt_q == CNT_TRUNC) begin
                        ovf_d   = 1'b1;
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // Discard the remainder of the truncated packet up to its own last byte.
                rd_w[gidx_q] = g_vld;
                if (g_vld && g_last) begin
                    rr_ptr_d = ptr_next;
                    grant_d  = '0;
                    gap_d    = '0;
                    state_d  = (IPG_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) state_d = ST_IDLE;
                else                   gap_d   = gap_q + 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_txmac_clk) begin
        if (i_txmac_srst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            ovf_q    <= ovf_d;
        end
    end

    // Outputs are forced to their idle values for the whole reset cycle, not only after the edge.
    assign o_src_byte_rd    = i_txmac_srst ? '0 : rd_w;
    assign o_byte_vld       = !i_txmac_srst && vld_w;
    assign o_last_byte      = !i_txmac_srst && last_w;
    assign o_byte           = g_byte;
    assign o_grant          = i_txmac_srst ? '0 : grant_q;
    assign o_busy           = !i_txmac_srst && (state_q != ST_IDLE);
    assign o_oversize_error = !i_txmac_srst && ovf_q;

endmodule

// File: doc/eth_tx_pkt_arbiter.md
ETH_TX_PKT_ARBITER -- requirements
Module: eth_tx_pkt_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRCS, default 4: number of packet byte-stream requesters, 2..8.
REQ-002 SHALL have parameter MAX_PKT_BYTES, default 1518: longest legal packet in bytes.
REQ-003 SHALL have parameter IPG_CYCLES, default 12: idle cycles forced between granted packets, 0..255.
REQ-004 SHALL have port i_txmac_clk  in  1  sole clock.
REQ-005 SHALL have port i_txmac_srst  in  1  reset, synchronous to i_txmac_clk, active-high.
REQ-006 SHALL have port i_src_byte  in  [0:NUM_SRCS-1][7:0]  per-source head byte.
REQ-007 SHALL have port i_src_byte_vld  in  [0:NUM_SRCS-1]  head byte valid.
REQ-008 SHALL have port i_src_last_byte  in  [0:NUM_SRCS-1]  head byte ends packet.
REQ-009 SHALL have port o_src_byte_rd  out  [0:NUM_SRCS-1]  pop head byte of source.
REQ-010 SHALL have port o_byte  out  8  arbitrated byte to TX MAC adapter.
REQ-011 SHALL have port o_byte_vld  out  1  o_byte valid.
REQ-012 SHALL have port o_last_byte  out  1  o_byte ends packet.
REQ-013 SHALL have port i_byte_rd  in  1  downstream pops o_byte.
REQ-014 SHALL have port o_grant  out  [0:NUM_SRCS-1]  one-hot current owner; zero when none.
REQ-015 SHALL have port o_busy  out  1  high in any state except IDLE.
REQ-016 SHALL have port o_oversize_error  out  1  one-cycle pulse on packet truncation.

Function
REQ-017 SHALL implement a registered FSM with states IDLE, XFER, FLUSH, GAP.
REQ-018 In IDLE, SHALL scan i_src_byte_vld round-robin starting at rr_ptr, register winner into o_grant, go to XFER next cycle; stay IDLE if none valid.
REQ-019 SHALL grant whole packets only; no source change until last byte popped, truncation, or reset.
REQ-020 In XFER, SHALL drive o_byte/o_byte_vld/o_last_byte combinationally from the granted source; o_src_byte_rd[g] = i_byte_rd AND i_src_byte_vld[g]; all other o_src_byte_rd low.
REQ-021 A byte SHALL transfer only on cycles where o_byte_vld AND i_byte_rd; source bubbles (vld low) SHALL pass through as o_byte_vld low without losing grant.
REQ-022 SHALL count transferred bytes in a counter of width clog2(MAX_PKT_BYTES+1), cleared on entry to XFER.
REQ-023 On transfer of a byte with i_src_last_byte high, SHALL set rr_ptr = (g+1) mod NUM_SRCS and go to GAP (or IDLE if IPG_CYCLES=0).
REQ-024 On transfer of byte number MAX_PKT_BYTES without last, SHALL force o_last_byte high on that byte, pulse o_oversize_error the following cycle, go to FLUSH.
REQ-025 A packet of exactly MAX_PKT_BYTES with last on final byte SHALL NOT trigger truncation.
REQ-026 In FLUSH, SHALL hold o_byte_vld low and assert o_src_byte_rd[g] whenever i_src_byte_vld[g], discarding bytes until the last byte is popped, then update rr_ptr and go to GAP.
REQ-027 In GAP, SHALL hold o_byte_vld and all o_src_byte_rd low, o_grant zero, for exactly IPG_CYCLES cycles, then go to IDLE.
REQ-028 Minimum spacing: grant register to first o_byte_vld SHALL be zero cycles (valid in first XFER cycle if source valid); last-byte pop to next grant SHALL be IPG_CYCLES+1 cycles.
REQ-029 o_byte_vld, o_last_byte, o_src_byte_rd SHALL be low in IDLE, GAP; o_byte value is don't-care when o_byte_vld low.
REQ-030 Sources becoming valid during XFER/FLUSH/GAP SHALL be considered only at next IDLE scan.

Reset
REQ-031 While i_txmac_srst high: state=IDLE, rr_ptr=0, o_grant=0, counters=0, o_oversize_error=0, o_busy=0, all o_src_byte_rd=0, o_byte_vld=0, o_last_byte=0.
REQ-032 Reset asserted mid-packet SHALL abandon the packet without further pops; source realignment is the source's responsibility.

Structure
REQ-033 SHALL place the state enum type and helper function for round-robin selection in shared package eth_tx_pkg.
REQ-034 SHALL instantiate one sub-module rr_arbiter (NUM_SRCS requests, pointer in, one-hot grant out, combinational).

Verification
REQ-035 Single source 1, 60-byte packet, i_byte_rd always 1 -> 60 bytes out in order, o_last_byte on byte 60, o_grant=0100, 12 GAP cycles.
REQ-036 All four sources valid continuously with 64-byte packets -> grant order 0,1,2,3,0; no interleaving; 13 cycles from each last pop to next grant.
REQ-037 Source 2 sends 1600 bytes without last, MAX_PKT_BYTES=1518 -> 1518 bytes out, last on byte 1518, o_oversize_error one pulse, 82 bytes flushed, next grant to source 3.
REQ-038 Random i_byte_rd (50%) and source vld bubbles -> output stream bit-exact vs per-source scoreboard, no pops while o_byte_vld low in XFER.
REQ-039 Reset asserted at byte 30 of 64-byte packet -> all outputs reset values next cycle; rr_ptr=0, source 0 granted first after release.
REQ-040 One-byte packet (vld and last together) with IPG_CYCLES=0 -> single byte with o_last_byte, IDLE next cycle, back-to-back grant to next source.
